wt_dcache_mem_resp: RTL and testbench

WT_DCACHE_MEM_RESP -- requirements
Module: wt_dcache_mem_resp

---
 rtl/wt_dcache_mem_resp_if.sv | 86 ++++++++
 rtl/wt_dcache_mem_resp.sv | 221 ++++++++++++++++++++++
 tb/tb_wt_dcache_mem_resp.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_dcache_mem_resp_if.sv
// ---------------------------------------------------------------------------
// wt_dcache_mem_resp_pkg / wt_dcache_mem_resp_if
// Request/return types shared by the dcache and the memory responder, plus
// the interface carrying the dcache memory request and return channels.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wt_dcache_mem_resp_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int DCACHE_TID_WIDTH  = 4;
  localparam int PADDR_WIDTH       = 32;

  typedef enum logic [1:0] {
    DCACHE_LOAD_REQ   = 2'd0,
    DCACHE_STORE_REQ  = 2'd1,
    DCACHE_ATOMIC_REQ = 2'd2
  } dcache_in_t;

  typedef enum logic [1:0] {
    DCACHE_LOAD_ACK   = 2'd0,
    DCACHE_STORE_ACK  = 2'd1,
    DCACHE_INV_REQ    = 2'd2,
    DCACHE_ATOMIC_ACK = 2'd3
  } dcache_out_t;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_LR   = 4'd1,
    AMO_SC   = 4'd2,
    AMO_SWAP = 4'd3,
    AMO_ADD  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_XOR  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MAXU = 4'd9,
    AMO_MIN  = 4'd10,
    AMO_MINU = 4'd11,
    AMO_CAS1 = 4'd12,
    AMO_CAS2 = 4'd13
  } amo_t;

  typedef struct packed {
    dcache_in_t                  rtype;
    logic [2:0]                  size;
    logic [DCACHE_TID_WIDTH-1:0] tid;
    logic                        nc;
    logic [PADDR_WIDTH-1:0]      paddr;
    logic [63:0]                 data;
    amo_t                        amo_op;
  } dcache_req_t;

  typedef struct packed {
    dcache_out_t                  rtype;
    logic [DCACHE_TID_WIDTH-1:0]  tid;
    logic                         inv;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } dcache_rtrn_t;

endpackage

interface wt_dcache_mem_resp_if;
  import wt_dcache_mem_resp_pkg::*;

  logic         mem_data_req_i;
  logic         mem_data_ack_o;
  dcache_req_t  mem_data_i;
  logic         mem_rtrn_vld_o;
  dcache_rtrn_t mem_rtrn_o;

  // dcache side
  modport master (
    output mem_data_req_i, mem_data_i,
    input  mem_data_ack_o, mem_rtrn_vld_o, mem_rtrn_o
  );

  // memory responder side
  modport slave (
    input  mem_data_req_i, mem_data_i,
    output mem_data_ack_o, mem_rtrn_vld_o, mem_rtrn_o
  );
endinterface

`default_nettype wire

// File: rtl/wt_dcache_mem_resp.sv
// ---------------------------------------------------------------------------
// wt_dcache_mem_resp
// Behavioural memory responder for the write-through dcache: queues requests,
// waits RespLatency cycles per request, then serves loads, stores and (when
// WT_DCACHE_RESP_AMO_EN is defined) atomics from a 64-bit-word backing store.
// Optional feature macro: WT_DCACHE_RESP_AMO_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wt_dcache_mem_resp
  import wt_dcache_mem_resp_pkg::*;
#(
  parameter int MemWords     = 1024,
  parameter int RespLatency  = 2,
  parameter int ReqFifoDepth = 4
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  wt_dcache_mem_resp_if.slave  bus
);

  localparam int         IdxW      = $clog2(MemWords);
  localparam int         PtrW      = $clog2(ReqFifoDepth);
  localparam int         LineWords = DCACHE_LINE_WIDTH / 64;
  localparam int         LaneW     = $clog2(LineWords);
  localparam logic [3:0] LatInit   = 4'(RespLatency);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   lat_cnt;
  dcache_req_t  work;
  logic         rtrn_vld;
  dcache_rtrn_t rtrn_hold;

  dcache_req_t  fifo [ReqFifoDepth];
  logic [PtrW:0] wr_ptr;
  logic [PtrW:0] rd_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;

  logic [63:0]     store [MemWords];
  logic [IdxW-1:0] idx;
  logic [LaneW-1:0] lane;
  logic [63:0]     old_word;
  logic [7:0]      byte_en;
  dcache_rtrn_t    resp;
  logic            wr_en;
  logic [63:0]     wr_data;

  // Byte enables of a naturally aligned 1/2/4/8-byte access.
  function automatic logic [7:0] size_to_be(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    size_to_be = 8'h01 << off;
      2'd1:    size_to_be = 8'h03 << {off[2:1], 1'b0};
      2'd2:    size_to_be = 8'h0f << {off[2], 2'b00};
      default: size_to_be = 8'hff;
    endcase
  endfunction

  // Full counts as full even if a pop happens this cycle: no same-cycle bypass.
  assign fifo_full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) && (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign push       = bus.mem_data_req_i & ~fifo_full & ~rst_i;

  assign bus.mem_data_ack_o = push;
  assign bus.mem_rtrn_vld_o = rtrn_vld;
  assign bus.mem_rtrn_o     = rtrn_vld ? resp : rtrn_hold;

  // Word index wraps naturally through the truncated address slice.
  assign idx      = work.paddr[IdxW+2:3];
  assign lane     = idx[LaneW-1:0];
  assign old_word = store[idx];
  assign byte_en  = size_to_be(work.size[1:0], work.paddr[2:0]);

`ifdef WT_DCACHE_RESP_AMO_EN
  logic        amo_is32;
  logic        amo_hi;
  logic [31:0] amo_a32;
  logic [31:0] amo_b32;
  logic [63:0] amo_as, amo_au, amo_bs, amo_bu, amo_res;
  logic        amo_wr;
  logic [63:0] amo_wdata;
  logic [63:0] amo_old;
  logic        unused_bits;

  assign unused_bits = ^{work.paddr[PADDR_WIDTH-1:IdxW+3], work.size[2]};

  // Atomic ALU: operands are the addressed 32-bit half or the full word.
  always_comb begin
    amo_is32 = (work.size[1:0] != 2'b11);
    amo_hi   = work.paddr[2];
    amo_a32  = amo_hi ? old_word[63:32] : old_word[31:0];
    amo_b32  = amo_hi ? work.data[63:32] : work.data[31:0];
    amo_as   = amo_is32 ? {{32{amo_a32[31]}}, amo_a32} : old_word;
    amo_au   = amo_is32 ? {32'b0, amo_a32} : old_word;
    amo_bs   = amo_is32 ? {{32{amo_b32[31]}}, amo_b32} : work.data;
    amo_bu   = amo_is32 ? {32'b0, amo_b32} : work.data;
    amo_wr   = 1'b1;
    amo_res  = amo_bu;
    case (work.amo_op)
      AMO_SWAP, AMO_SC: amo_res = amo_bu;
      AMO_ADD:  amo_res = amo_au + amo_bu;
      AMO_AND:  amo_res = amo_au & amo_bu;
      AMO_OR:   amo_res = amo_au | amo_bu;
      AMO_XOR:  amo_res = amo_au ^ amo_bu;
      AMO_MAX:  amo_res = ($signed(amo_as) > $signed(amo_bs)) ? amo_au : amo_bu;
      AMO_MAXU: amo_res = (amo_au > amo_bu) ? amo_au : amo_bu;
      AMO_MIN:  amo_res = ($signed(amo_as) < $signed(amo_bs)) ? amo_au : amo_bu;
      AMO_MINU: amo_res = (amo_au < amo_bu) ? amo_au : amo_bu;
      default: begin
        // LR and unsupported ops only read.
        amo_wr  = 1'b0;
        amo_res = amo_au;
      end
    endcase
    amo_wdata = amo_is32 ? (amo_hi ? {amo_res[31:0], old_word[31:0]}
                                   : {old_word[63:32], amo_res[31:0]})
                         : amo_res;
    amo_old   = amo_is32 ? (amo_hi ? {amo_a32, 32'b0} : {32'b0, amo_a32}) : old_word;
  end
`else
  logic unused_bits;

  assign unused_bits = ^{work.paddr[PADDR_WIDTH-1:IdxW+3], work.size[2], work.amo_op};
`endif

  // Response and write-back for the request held in the working register.
  always_comb begin
    resp      = '0;
    resp.tid  = work.tid;
    resp.inv  = 1'b0;
    resp.rtype = DCACHE_LOAD_ACK;
    wr_en     = 1'b0;
    wr_data   = old_word;
    case (work.rtype)
      DCACHE_STORE_REQ: begin
        resp.rtype = DCACHE_STORE_ACK;
        wr_en      = 1'b1;
        for (int b = 0; b < 8; b++) begin
          if (byte_en[b]) wr_data[8*b +: 8] = work.data[8*b +: 8];
        end
      end
      DCACHE_ATOMIC_REQ: begin
        resp.rtype = DCACHE_ATOMIC_ACK;
`ifdef WT_DCACHE_RESP_AMO_EN
        wr_en   = amo_wr;
        wr_data = amo_wdata;
        if (work.amo_op != AMO_SC) resp.data[{lane, 6'd0} +: 64] = amo_old;
`endif
      end
      default: begin
        for (int i = 0; i < LineWords; i++) begin
          resp.data[64*i +: 64] = work.nc ? old_word : store[{idx[IdxW-1:LaneW], LaneW'(i)}];
        end
      end
    endcase
  end

  // Request queue storage; pointers live with the FSM.
  always_ff @(posedge clk_i) begin
    if (push) fifo[wr_ptr[PtrW-1:0]] <= bus.mem_data_i;
  end

  // Backing store commit; a reset during RESP leaves RESP before any edge can write.
  always_ff @(posedge clk_i) begin
    if (state == S_RESP && wr_en && !rst_i) store[idx] <= wr_data;
  end

  // Control FSM: pop, wait RespLatency cycles, answer for one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      lat_cnt   <= 4'd0;
      work      <= '0;
      rtrn_vld  <= 1'b0;
      rtrn_hold <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      rtrn_vld <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            work   <= fifo[rd_ptr[PtrW-1:0]];
            rd_ptr <= rd_ptr + 1'b1;
            if (RespLatency == 0) begin
              state    <= S_RESP;
              rtrn_vld <= 1'b1;
            end else begin
              lat_cnt <= LatInit;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state    <= S_RESP;
            rtrn_vld <= 1'b1;
          end
        end
        S_RESP: begin
          rtrn_hold <= resp;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wt_dcache_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_wt_dcache_mem_resp
// Randomised and directed stimulus for wt_dcache_mem_resp, checked against a
// word/byte-level memory model and an in-order scoreboard.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wt_dcache_mem_resp;
  import wt_dcache_mem_resp_pkg::*;

  localparam int MEM_WORDS = 16;
  localparam int LAT       = 2;
  localparam int DEPTH     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wt_dcache_mem_resp_if bus();

  wt_dcache_mem_resp #(
    .MemWords    (MEM_WORDS),
    .RespLatency (LAT),
    .ReqFifoDepth(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  int           stalls   = 0;
  logic [63:0]  mm [MEM_WORDS];
  dcache_rtrn_t exp_q [$];
  dcache_rtrn_t last_rtrn = '0;

  task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic dcache_req_t mk(input dcache_in_t t, input logic [2:0] sz, input logic [3:0] tid,
                                     input logic nc, input logic [31:0] pa, input logic [63:0] d,
                                     input amo_t op);
    dcache_req_t r;
    r.rtype = t; r.size = sz; r.tid = tid; r.nc = nc; r.paddr = pa; r.data = d; r.amo_op = op;
    return r;
  endfunction

  // Reference: applies the request to the model memory, returns the expected answer.
  function automatic dcache_rtrn_t model(input dcache_req_t r);
    dcache_rtrn_t e;
    int idx, lane, base, nb, start;
    logic [63:0] w;
    e = '0;
    e.tid = r.tid;
    idx  = int'((r.paddr >> 3) % MEM_WORDS);
    lane = idx % 2;
    w    = mm[idx];
    case (r.rtype)
      DCACHE_STORE_REQ: begin
        e.rtype = DCACHE_STORE_ACK;
        nb    = 1 << r.size[1:0];
        start = (int'(r.paddr[2:0]) / nb) * nb;
        for (int b = start; b < start + nb; b++) mm[idx][8*b +: 8] = r.data[8*b +: 8];
      end
      DCACHE_ATOMIC_REQ: begin
        e.rtype = DCACHE_ATOMIC_ACK;
`ifdef WT_DCACHE_RESP_AMO_EN
        begin
          bit is32; int sh; logic [63:0] mask, oldv, opd, res; longint sa, sb; int s32; bit wr;
          is32 = (r.size[1:0] != 2'd3);
          sh   = is32 ? 32 * int'(r.paddr[2]) : 0;
          mask = is32 ? (64'hFFFF_FFFF << sh) : '1;
          oldv = (w & mask) >> sh;
          opd  = (r.data & mask) >> sh;
          if (is32) begin
            s32 = int'(oldv[31:0]); sa = s32;
            s32 = int'(opd[31:0]);  sb = s32;
          end else begin
            sa = longint'(oldv); sb = longint'(opd);
          end
          wr = 1; res = opd;
          case (r.amo_op)
            AMO_ADD:  res = oldv + opd;
            AMO_AND:  res = oldv & opd;
            AMO_OR:   res = oldv | opd;
            AMO_XOR:  res = oldv ^ opd;
            AMO_MAX:  res = (sa > sb) ? oldv : opd;
            AMO_MAXU: res = (oldv > opd) ? oldv : opd;
            AMO_MIN:  res = (sa < sb) ? oldv : opd;
            AMO_MINU: res = (oldv < opd) ? oldv : opd;
            AMO_SWAP, AMO_SC: res = opd;
            default:  wr = 0;
          endcase
          if (wr) mm[idx] = (w & ~mask) | ((res << sh) & mask);
          if (r.amo_op != AMO_SC) e.data[64*lane +: 64] = oldv << sh;
        end
`endif
      end
      default: begin
        e.rtype = DCACHE_LOAD_ACK;
        if (r.nc) e.data = {w, w};
        else begin
          base = idx - lane;
          e.data = {mm[base+1], mm[base]};
        end
      end
    endcase
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input dcache_req_t r, input bit track);
    int t;
    bus.mem_data_req_i = 1'b1;
    bus.mem_data_i     = r;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.mem_data_ack_o) break;
      stalls++;
    end
    if (t == 200) check_val("ack_timeout", 160'd0, 160'd1);
    else if (track) exp_q.push_back(model(r));
    @(posedge clk); #1;
    bus.mem_data_req_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check_val("drain", 160'(exp_q.size()), 160'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every pulse matches the oldest expectation; idle cycles hold.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) last_rtrn = '0;
      else if (bus.mem_rtrn_vld_o) begin
        if (exp_q.size() == 0) check_val("spurious_rtrn", 160'd1, 160'd0);
        else check_val("rtrn", 160'(bus.mem_rtrn_o), 160'(exp_q.pop_front()));
        last_rtrn = bus.mem_rtrn_o;
      end else begin
        check_val("hold", 160'(bus.mem_rtrn_o), 160'(last_rtrn));
      end
    end
  end

  initial begin
    int first, pulses;
    bus.mem_data_req_i = 1'b1;
    bus.mem_data_i     = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ack",  160'(bus.mem_data_ack_o), 160'd0);
    check_val("rst_vld",  160'(bus.mem_rtrn_vld_o), 160'd0);
    check_val("rst_rtrn", 160'(bus.mem_rtrn_o), 160'd0);
    bus.mem_data_req_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Known contents for the whole store.
    for (int i = 0; i < MEM_WORDS; i++)
      send(mk(DCACHE_STORE_REQ, 3'd3, 4'(i), 1'b0, 32'(i*8), {$urandom, $urandom}, AMO_NONE), 1'b1);

    // Full-word store then nc load replicates the word.
    send(mk(DCACHE_STORE_REQ, 3'd3, 4'd1, 1'b0, 32'h40, 64'h1122334455667788, AMO_NONE), 1'b1);
    send(mk(DCACHE_LOAD_REQ,  3'd3, 4'd2, 1'b1, 32'h40, 64'd0, AMO_NONE), 1'b1);
    drain();
    check_val("nc_repl", 160'(last_rtrn.data), 160'({2{64'h1122334455667788}}));

    // Single-load latency from an idle, empty responder.
    send(mk(DCACHE_LOAD_REQ, 3'd3, 4'd5, 1'b0, 32'h10, 64'd0, AMO_NONE), 1'b1);
    first = 0; pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.mem_rtrn_vld_o) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check_val("lat_cycle",  160'(first), 160'(2 + LAT));
    check_val("lat_pulses", 160'(pulses), 160'd1);
    check_val("lat_tid",    160'(last_rtrn.tid), 160'd5);
    @(posedge clk); #1;

    // Six back-to-back: exactly one stalled cycle with depth 4 and latency 2.
    stalls = 0;
    for (int i = 0; i < 6; i++)
      send(mk(($urandom_range(0, 1) != 0) ? DCACHE_STORE_REQ : DCACHE_LOAD_REQ, 3'($urandom_range(0, 3)),
              4'(i + 8), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), {$urandom, $urandom}, AMO_NONE), 1'b1);
    check_val("full_stalls", 160'(stalls), 160'd1);
    drain();

    // 32-bit AMO_ADD on a word holding 7.
    send(mk(DCACHE_STORE_REQ,  3'd3, 4'd3, 1'b0, 32'h18, 64'h7, AMO_NONE), 1'b1);
    send(mk(DCACHE_ATOMIC_REQ, 3'd2, 4'd4, 1'b0, 32'h18, 64'h3, AMO_ADD), 1'b1);
    send(mk(DCACHE_LOAD_REQ,   3'd3, 4'd6, 1'b1, 32'h18, 64'd0, AMO_NONE), 1'b1);
    drain();
`ifdef WT_DCACHE_RESP_AMO_EN
    check_val("amo_after", 160'(last_rtrn.data[63:0]), 160'h000000000000000A);
`else
    check_val("amo_after", 160'(last_rtrn.data[63:0]), 160'h0000000000000007);
`endif

    // Word index MemWords+1 aliases onto word 1.
    send(mk(DCACHE_STORE_REQ, 3'd3, 4'd7, 1'b0, 32'((MEM_WORDS + 1) * 8), 64'hCAFEF00D12345678, AMO_NONE), 1'b1);
    send(mk(DCACHE_LOAD_REQ,  3'd3, 4'd8, 1'b1, 32'h8, 64'd0, AMO_NONE), 1'b1);
    drain();
    check_val("alias", 160'(last_rtrn.data[63:0]), 160'hCAFEF00D12345678);

    // Reset while a store waits: no pulse, zero outputs, no write.
    send(mk(DCACHE_STORE_REQ, 3'd3, 4'd9, 1'b0, 32'h20, 64'hDEADBEEFDEADBEEF, AMO_NONE), 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    bus.mem_data_req_i = 1'b1;
    @(negedge clk);
    check_val("rstw_vld",  160'(bus.mem_rtrn_vld_o), 160'd0);
    check_val("rstw_rtrn", 160'(bus.mem_rtrn_o), 160'd0);
    check_val("rstw_ack",  160'(bus.mem_data_ack_o), 160'd0);
    bus.mem_data_req_i = 1'b0;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mem_rtrn_vld_o) pulses++;
    end
    check_val("rstw_nopulse", 160'(pulses), 160'd0);
    @(posedge clk); #1;
    send(mk(DCACHE_LOAD_REQ, 3'd3, 4'd10, 1'b1, 32'h20, 64'd0, AMO_NONE), 1'b1);
    drain();

    // Random traffic with random idle gaps.
    for (int n = 0; n < 80; n++) begin
      send(mk(dcache_in_t'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 32'($urandom_range(0, 2 * MEM_WORDS * 8 - 1)),
              {$urandom, $urandom}, amo_t'($urandom_range(1, 11))), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
